// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_pkg: shared types and helpers for the MEM/WB stage.
// Contents:
//   acc_state_t : access FSM states (IDLE, MISS_WAIT, DONE_HOLD)
//   sat_inc     : saturating increment for counters of width w (w <= 64)
package mem_wb_pkg;

    typedef enum logic [1:0] {IDLE, MISS_WAIT, DONE_HOLD} acc_state_t;

    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] max_v;
        max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= max_v) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: data-cache bus between the MEM/WB stage and the cache.
// Signals:
//   cache_addr, cache_rd_req, cache_wr_req, cache_wr_data : stage -> cache
//   cache_rd_data, cache_miss                             : cache -> stage
// Modports: master (stage side), slave (cache side).
interface mem_wb_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] cache_addr;
    logic              cache_rd_req;
    logic              cache_wr_req;
    logic [DATA_W-1:0] cache_wr_data;
    logic [DATA_W-1:0] cache_rd_data;
    logic              cache_miss;

    modport master (
        output cache_addr, cache_rd_req, cache_wr_req, cache_wr_data,
        input  cache_rd_data, cache_miss
    );

    modport slave (
        input  cache_addr, cache_rd_req, cache_wr_req, cache_wr_data,
        output cache_rd_data, cache_miss
    );
endinterface

// File: rtl/mem_wb_stage_stats.sv
// mem_access_stats: access FSM, stall request and saturating hit/miss/miss-cycle counters.
// Ports:
//   clk, rst (async, active-low), en (stage enable), req (cache access this cycle),
//   cache_miss, stat_clr (sync clear, beats increments),
//   stall_req (combinational), hit_count, miss_count, miss_cycles.
module mem_access_stats
    import mem_wb_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             req,
    input  logic             cache_miss,
    input  logic             stat_clr,
    output logic             stall_req,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] miss_cycles
);
    acc_state_t state;
    logic       hit_inc;
    logic       miss_inc;

    // Accesses are only counted from IDLE, so a stalled access is seen once.
    assign hit_inc   = (state == IDLE) && req && !cache_miss;
    assign miss_inc  = (state == IDLE) && req && cache_miss;
    assign stall_req = miss_inc || ((state == MISS_WAIT) && cache_miss);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            hit_count   <= '0;
            miss_count  <= '0;
            miss_cycles <= '0;
        end else begin
            case (state)
                IDLE:      state <= miss_inc ? MISS_WAIT : (hit_inc && !en) ? DONE_HOLD : IDLE;
                MISS_WAIT: state <= cache_miss ? MISS_WAIT : en ? IDLE : DONE_HOLD;
                DONE_HOLD: state <= en ? IDLE : DONE_HOLD;
                default:   state <= IDLE;
            endcase
            hit_count   <= stat_clr ? '0 : hit_inc ? CNT_W'(sat_inc(64'(hit_count), CNT_W)) : hit_count;
            miss_count  <= stat_clr ? '0 : miss_inc ? CNT_W'(sat_inc(64'(miss_count), CNT_W)) : miss_count;
            miss_cycles <= stat_clr ? '0 : stall_req ? CNT_W'(sat_inc(64'(miss_cycles), CNT_W)) : miss_cycles;
        end
    end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB segment register fronting a data cache, with load-data hold and access stats.
// Ports:
//   clk, rst (async, active-low), en (0 = hold), flush (clears W controls when en=1)
//   M-stage inputs: mem_addr, mem_wdata, mem_we, mem_to_reg_m, result_m, rd_m, reg_write_m
//   cache (mem_wb_stage_if.master): combinational pass-through plus cache_rd_data / cache_miss
//   stall_req, rd_data_w, loaded_bytes_select_w, result_w, rd_w, reg_write_w, mem_to_reg_w
//   stat_clr, hit_count, miss_count, miss_cycles
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int RW_W       = 3,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  flush,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W/8-1:0]   mem_we,
    input  logic                  mem_to_reg_m,
    input  logic [DATA_W-1:0]     result_m,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic [RW_W-1:0]       reg_write_m,
    mem_wb_stage_if.master        cache,
    output logic                  stall_req,
    output logic [DATA_W-1:0]     rd_data_w,
    output logic [1:0]            loaded_bytes_select_w,
    output logic [DATA_W-1:0]     result_w,
    output logic [REG_ADDR_W-1:0] rd_w,
    output logic [RW_W-1:0]       reg_write_w,
    output logic                  mem_to_reg_w,
    input  logic                  stat_clr,
    output logic [CNT_W-1:0]      hit_count,
    output logic [CNT_W-1:0]      miss_count,
    output logic [CNT_W-1:0]      miss_cycles
);
    logic              hold_valid;
    logic [DATA_W-1:0] hold_data;

    assign cache.cache_addr    = mem_addr;
    assign cache.cache_rd_req  = mem_to_reg_m;
    assign cache.cache_wr_req  = |mem_we;
    assign cache.cache_wr_data = mem_wdata;

    // The cache may drop its read data while the pipeline is stalled,
    // so the value seen in the first stalled cycle is captured and replayed.
    assign rd_data_w = hold_valid ? hold_data : cache.cache_rd_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_valid            <= 1'b0;
            hold_data             <= '0;
            result_w              <= '0;
            rd_w                  <= '0;
            reg_write_w           <= '0;
            mem_to_reg_w          <= 1'b0;
            loaded_bytes_select_w <= '0;
        end else begin
            hold_valid <= !en;
            if (!en) hold_data <= rd_data_w;
            if (en) begin
                result_w              <= flush ? '0 : result_m;
                rd_w                  <= flush ? '0 : rd_m;
                reg_write_w           <= flush ? '0 : reg_write_m;
                mem_to_reg_w          <= flush ? 1'b0 : mem_to_reg_m;
                loaded_bytes_select_w <= flush ? 2'b00 : mem_addr[1:0];
            end
        end
    end

    mem_access_stats #(.CNT_W(CNT_W)) u_stats (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req        (cache.cache_rd_req | cache.cache_wr_req),
        .cache_miss (cache.cache_miss),
        .stat_clr   (stat_clr),
        .stall_req  (stall_req),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .miss_cycles(miss_cycles)
    );
endmodule
